// File: rtl/traffic_light.sv
// Single-road traffic light controller. Moore FSM cycling RED -> GREEN -> YELLOW -> RED,
// each phase held for its own programmable number of clock cycles.
module traffic_light #(
  parameter int unsigned RED_CYCLES    = 5,
  parameter int unsigned GREEN_CYCLES  = 5,
  parameter int unsigned YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] y
);

  // Reject dwell times the 8-bit counter cannot represent.
  if (RED_CYCLES < 1 || RED_CYCLES > 255) begin : g_bad_red
    $error("traffic_light: RED_CYCLES must be in 1..255");
  end
  if (GREEN_CYCLES < 1 || GREEN_CYCLES > 255) begin : g_bad_green
    $error("traffic_light: GREEN_CYCLES must be in 1..255");
  end
  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 255) begin : g_bad_yellow
    $error("traffic_light: YELLOW_CYCLES must be in 1..255");
  end

  // Terminal counter value for each phase (N-1).
  localparam logic [7:0] RedLast    = 8'(RED_CYCLES - 1);
  localparam logic [7:0] GreenLast  = 8'(GREEN_CYCLES - 1);
  localparam logic [7:0] YellowLast = 8'(YELLOW_CYCLES - 1);

  typedef enum logic [1:0] {
    StRed    = 2'b00,
    StGreen  = 2'b01,
    StYellow = 2'b10
  } state_e;

  state_e     r_state;
  logic [7:0] r_cnt;

  // Phase sequencing and dwell counting; the final edge of a phase loads the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StRed;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        StRed: begin
          if (r_cnt == RedLast) begin
            r_state <= StGreen;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StGreen: begin
          if (r_cnt == GreenLast) begin
            r_state <= StYellow;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StYellow: begin
          if (r_cnt == YellowLast) begin
            r_state <= StRed;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // Unreachable encoding recovers to a clean RED phase.
        default: begin
          r_state <= StRed;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Light code depends on the state register only, so it never glitches between edges.
  always_comb begin
    y = 2'b00;
    case (r_state)
      StRed:    y = 2'b00;
      StGreen:  y = 2'b01;
      StYellow: y = 2'b10;
      default:  y = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: three instances (default, minimum and asymmetric dwell times)
// checked against a position-in-period model through a scoreboard queue per instance.
module tb_traffic_light;

  logic       clk;
  logic       rst;
  logic [1:0] y_def;
  logic [1:0] y_min;
  logic [1:0] y_asy;

  int n_vec;
  int n_err;
  int unsigned k;  // edges sampled with rst high since the last reset

  logic [1:0] q_def[$];
  logic [1:0] q_min[$];
  logic [1:0] q_asy[$];

  traffic_light u_def (
    .clk (clk),
    .rst (rst),
    .y   (y_def)
  );

  traffic_light #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1)
  ) u_min (
    .clk (clk),
    .rst (rst),
    .y   (y_min)
  );

  traffic_light #(
    .RED_CYCLES    (7),
    .GREEN_CYCLES  (3),
    .YELLOW_CYCLES (4)
  ) u_asy (
    .clk (clk),
    .rst (rst),
    .y   (y_asy)
  );

  // 20 ns clock period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Expected light after kk edges from release, given the three dwell times.
  function automatic logic [1:0] exp_y(input int unsigned kk, input int unsigned r,
                                       input int unsigned g, input int unsigned yl);
    int unsigned p;
    p = kk % (r + g + yl);
    if (p < r) return 2'b00;
    if (p < r + g) return 2'b01;
    return 2'b10;
  endfunction

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b (k=%0d)", tag, $time, got, want, k);
    end
  endtask

  task automatic push_all();
    q_def.push_back(exp_y(k, 5, 5, 2));
    q_min.push_back(exp_y(k, 1, 1, 1));
    q_asy.push_back(exp_y(k, 7, 3, 4));
  endtask

  task automatic pop_check(input string tag);
    if (q_def.size() == 0 || q_min.size() == 0 || q_asy.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s at %0t: scoreboard empty, got nothing, expected an entry", tag,
               $time);
    end else begin
      check({tag, "_def"}, y_def, q_def.pop_front());
      check({tag, "_min"}, y_min, q_min.pop_front());
      check({tag, "_asy"}, y_asy, q_asy.pop_front());
    end
  endtask

  // One clock edge: model the edge with the current rst, then compare just after it.
  task automatic step(input string tag);
    if (rst) k++;
    else k = 0;
    push_all();
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Assert reset between edges and check the light drops to RED before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    push_all();
    #1;
    pop_check(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    k     = 0;
    rst   = 1'b1;
    #1;
    rst = 1'b0;
    push_all();
    #1;
    pop_check("rst_async0");

    // Reset held across three edges.
    repeat (3) step("rst_hold");

    // Release and run two default periods (covers >=3 min periods too).
    rst = 1'b1;
    repeat (24) step("seq");

    // Advance to the third GREEN cycle of the default instance, then pulse reset.
    repeat (7) step("to_green");
    check("green3_def", y_def, 2'b01);
    async_reset("mid_rst");
    #2;
    rst = 1'b1;

    // Full dwell after release; 42 edges = three asymmetric periods.
    repeat (42) step("after_rst");

    // Free run of 20 cycles from a fresh release.
    async_reset("fr_rst");
    @(posedge clk);
    #1;
    check("fr_hold_def", y_def, 2'b00);
    rst = 1'b1;
    repeat (20) step("free_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
